// File: rtl/ad9228_fifo_drain.sv
// AD9228 FIFO drain: reads each channel's capture FIFO in fixed-length bursts, round-robin,
// and emits tagged 32-bit words on a valid/ready stream. Empty channels stall and then pad,
// so every burst always carries exactly BURST_LEN words.
module ad9228_fifo_drain #(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned AddrW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int unsigned BurstW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1,
  localparam int unsigned StallW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [AddrW-1:0]        fifo_addr,
  output logic [NUM_CHANNELS-1:0] fifo_rd_en,
  input  logic                    fifo_not_empty,
  input  logic                    fifo_full,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  output logic [31:0]             m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic [NUM_CHANNELS-1:0] ovf_flags,
  input  logic                    ovf_clr
);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StWaitData,
    StLatch,
    StSend
  } state_e;

  localparam logic [BurstW-1:0] LastBeat = BurstW'(BURST_LEN - 1);
  localparam logic [StallW-1:0] StallMax = StallW'(TIMEOUT_CYCLES - 1);
  localparam logic [AddrW-1:0]  LastCh   = AddrW'(NUM_CHANNELS - 1);

  state_e                         state_q, state_d;
  logic [AddrW-1:0]               ch_q, ch_d;
  logic [BurstW-1:0]              burst_q, burst_d;
  logic [StallW-1:0]              stall_q, stall_d;
  logic [NUM_CHANNELS-1:0][11:0]  seq_q, seq_d;
  logic [31:0]                    m_data_q, m_data_d;
  logic [NUM_CHANNELS-1:0]        ovf_q, ovf_d;

  logic [3:0]  ch_tag;
  logic [11:0] sample_ext;

  assign ch_tag     = 4'(ch_q);
  assign sample_ext = 12'(fifo_dout);

  // Next-state logic for the burst FSM, counters and the output word register.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    burst_d    = burst_q;
    stall_d    = stall_q;
    seq_d      = seq_q;
    m_data_d   = m_data_q;
    fifo_rd_en = '0;

    unique case (state_q)
      StIdle: begin
        if (en) state_d = StSelect;
      end
      StSelect: begin
        // Mux settle cycle after fifo_addr changes.
        state_d = StWaitData;
      end
      StWaitData: begin
        if (fifo_not_empty) begin
          fifo_rd_en[ch_q] = 1'b1;
          stall_d          = '0;
          state_d          = StLatch;
        end else if ((TIMEOUT_CYCLES != 0) && (stall_q == StallMax)) begin
          // Pad keeps burst framing intact; seq is not consumed so the gap is visible.
          m_data_d = {ch_tag, seq_q[ch_q], 1'b1, 3'b000, 12'h000};
          stall_d  = '0;
          state_d  = StSend;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      StLatch: begin
        m_data_d     = {ch_tag, seq_q[ch_q], 1'b0, 3'b000, sample_ext};
        seq_d[ch_q]  = seq_q[ch_q] + 12'd1;
        state_d      = StSend;
      end
      StSend: begin
        if (m_ready) begin
          if (burst_q == LastBeat) begin
            burst_d = '0;
            ch_d    = (ch_q == LastCh) ? '0 : ch_q + 1'b1;
            state_d = StIdle;
          end else begin
            burst_d = burst_q + 1'b1;
            state_d = StWaitData;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky overflow flags; a set in the same cycle as a clear wins.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = '0;
    if ((state_q != StIdle) && fifo_full) ovf_d[ch_q] = 1'b1;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      burst_q  <= '0;
      stall_q  <= '0;
      seq_q    <= '0;
      m_data_q <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      burst_q  <= burst_d;
      stall_q  <= stall_d;
      seq_q    <= seq_d;
      m_data_q <= m_data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fifo_addr = ch_q;
  assign m_data    = m_data_q;
  assign m_valid   = (state_q == StSend);
  assign m_last    = (state_q == StSend) && (burst_q == LastBeat);
  assign busy      = (state_q != StIdle);
  assign ovf_flags = ovf_q;

endmodule

// File: tb/tb_ad9228_fifo_drain.sv
// Bench for ad9228_fifo_drain: behavioural per-channel FIFOs feed the DUT, expected stream
// words are queued as stimulus is loaded and compared on every handshake.
module tb_ad9228_fifo_drain;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 12;
  localparam int unsigned BL  = 4;
  localparam int unsigned TO  = 8;

  logic        clk = 1'b0;
  logic        rst, en, m_ready, ovf_clr;
  logic        fifo_not_empty = 1'b0, fifo_full = 1'b0;
  logic [1:0]  fifo_addr;
  logic [3:0]  fifo_rd_en, ovf_flags;
  logic [11:0] fifo_dout = '0;
  logic [31:0] m_data;
  logic        m_valid, m_last, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  int rd_pulses = 0;
  int hs_cyc[$];

  typedef logic [11:0] fq_t[$];
  fq_t fq[NCH];
  logic [3:0]  full_src = '0;
  logic [3:0]  rd_lat = '0, prev_rd = '0;
  logic [11:0] seq_m[NCH];

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  ad9228_fifo_drain #(
    .NUM_CHANNELS  (NCH),
    .DATA_WIDTH    (DW),
    .BURST_LEN     (BL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_addr     (fifo_addr),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_not_empty(fifo_not_empty),
    .fifo_full     (fifo_full),
    .fifo_dout     (fifo_dout),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .busy          (busy),
    .ovf_flags     (ovf_flags),
    .ovf_clr       (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word(input int ch, input logic [11:0] seq, input logic pad,
                                       input logic [11:0] s);
    return {4'(ch), seq, pad, 3'b000, s};
  endfunction

  task automatic push_word(input int ch, input logic [11:0] s, input logic last);
    exp_q.push_back('{data: word(ch, seq_m[ch], 1'b0, s), last: last});
    seq_m[ch] = seq_m[ch] + 12'd1;
  endtask

  task automatic push_pad(input int ch, input logic last);
    exp_q.push_back('{data: word(ch, seq_m[ch], 1'b1, 12'h000), last: last});
  endtask

  task automatic load_burst(input int ch, input logic [11:0] base);
    for (int i = 0; i < int'(BL); i++) begin
      fq[ch].push_back(base + 12'(i));
      push_word(ch, base + 12'(i), i == int'(BL) - 1);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    chk("drain_sb_empty", exp_q.size(), 0);
    chk("drain_idle", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, ovf_flags, 0);
    chk({tag, "_addr"}, fifo_addr, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
  endtask

  // Behavioural FIFOs: a read strobe seen in one cycle presents data in the next.
  always @(posedge clk) begin
    for (int i = 0; i < int'(NCH); i++)
      if (rd_lat[i] && fq[i].size() != 0) fifo_dout <= fq[i].pop_front();
    #2;
    fifo_not_empty = (fq[fifo_addr].size() != 0);
    fifo_full      = full_src[fifo_addr];
  end

  // Read-strobe rules and scoreboard compare on each stream handshake.
  always @(negedge clk) begin
    rd_lat <= fifo_rd_en;
    if (fifo_rd_en != '0) begin
      rd_pulses++;
      chk("rd_onehot", 32'($onehot(fifo_rd_en)), 1);
      chk("rd_not_back_to_back", prev_rd, 0);
      chk("rd_matches_addr", fifo_rd_en, 4'b0001 << fifo_addr);
      chk("rd_only_busy", busy, 1);
    end
    prev_rd <= fifo_rd_en;
    if (!rst && m_valid && m_ready) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      chk("sb_word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data", m_data, e.data);
        chk("word_last", m_last, e.last);
      end
    end
  end

  initial begin
    int h0, en_cyc, p0, k, hp;
    logic [31:0] cap_d;
    logic        cap_l;

    for (int i = 0; i < int'(NCH); i++) seq_m[i] = '0;
    rst = 1'b1; en = 1'b0; m_ready = 1'b1; ovf_clr = 1'b0;

    // Reset and idle behaviour.
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    load_burst(0, 12'h001);
    p0 = rd_pulses;
    tick(100);
    chk("idle_no_rd", rd_pulses - p0, 0);
    chk("idle_no_word", hs_cnt, 0);

    // Basic burst on ch0, en pulsed for one cycle only.
    en = 1'b1; en_cyc = cyc; h0 = hs_cyc.size();
    tick(1);
    en = 1'b0;
    wait_drain(200);
    chk("basic_word_count", hs_cyc.size() - h0, BL);
    if (hs_cyc.size() - h0 == int'(BL)) begin
      chk("first_latency", hs_cyc[h0] - en_cyc, 4);
      for (int i = 1; i < int'(BL); i++) chk("word_gap", hs_cyc[h0+i] - hs_cyc[h0+i-1], 3);
    end
    chk("addr_next_ch", fifo_addr, 1);

    // Backpressure on ch1 word 0, then a pad for the empty FIFO.
    fq[1].push_back(12'h0A1);
    push_word(1, 12'h0A1, 1'b0);
    push_pad(1, 1'b0);
    m_ready = 1'b0; en = 1'b1;
    tick(1);
    en = 1'b0;
    k = 0;
    while (!m_valid && k < 20) begin tick(1); k++; end
    chk("bp_valid_seen", m_valid, 1);
    cap_d = m_data; cap_l = m_last; p0 = rd_pulses; h0 = hs_cnt;
    repeat (10) begin
      tick(1);
      chk("bp_data_stable", m_data, cap_d);
      chk("bp_last_stable", m_last, cap_l);
    end
    chk("bp_no_rd", rd_pulses - p0, 0);
    chk("bp_no_xfer", hs_cnt - h0, 0);
    hp = hs_cyc.size();
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    tick(2);
    chk("bp_one_xfer", hs_cnt - h0, 1);
    m_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin tick(1); k++; end
    chk("pad_seen", exp_q.size(), 0);
    if (hs_cyc.size() - hp == 2) chk("pad_gap", hs_cyc[hp+1] - hs_cyc[hp], 9);
    else chk("pad_word_count", hs_cyc.size() - hp, 2);
    fq[1].push_back(12'h0B2);
    fq[1].push_back(12'h0B3);
    push_word(1, 12'h0B2, 1'b0);
    push_word(1, 12'h0B3, 1'b1);
    wait_drain(200);

    // Round-robin across all channels with every FIFO reporting full.
    load_burst(2, 12'h200);
    load_burst(3, 12'h300);
    load_burst(0, 12'h010);
    load_burst(1, 12'h110);
    full_src = 4'hF; en = 1'b1;
    k = 0;
    while (!(fifo_addr == 2'd1 && busy) && k < 300) begin tick(1); k++; end
    en = 1'b0;
    wait_drain(400);
    full_src = 4'h0;
    chk("ovf_all_set", ovf_flags, 4'hF);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf_flags, 0);

    // Clear held across a ch2 burst that also sees full: set wins.
    load_burst(2, 12'h240);
    full_src = 4'b0100; ovf_clr = 1'b1; en = 1'b1;
    tick(1);
    en = 1'b0;
    wait_drain(200);
    ovf_clr = 1'b0; full_src = 4'h0;
    chk("ovf_set_wins", ovf_flags, 4'b0100);

    // Reset after the second word of a ch3 burst.
    for (int i = 0; i < int'(BL); i++) fq[3].push_back(12'h3A0 + 12'(i));
    push_word(3, 12'h3A0, 1'b0);
    push_word(3, 12'h3A1, 1'b0);
    h0 = hs_cnt; en = 1'b1;
    tick(1);
    en = 1'b0;
    k = 0;
    while (hs_cnt - h0 < 2 && k < 50) begin tick(1); k++; end
    chk("pre_reset_words", hs_cnt - h0, 2);
    rst = 1'b1;
    tick(1);
    check_all_zero("midreset");
    rst = 1'b0;
    fq[3].delete();
    for (int i = 0; i < int'(NCH); i++) seq_m[i] = '0;
    chk("midreset_sb_empty", exp_q.size(), 0);

    // After reset ch0 restarts with seq 0.
    load_burst(0, 12'h3C0);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    wait_drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9228_fifo_drain.md
Name: ad9228_fifo_drain

Overview:
- Downstream consumer of the AD9228 multi-channel capture block.
- Drives that block's per-channel FIFO read mux (address, one-hot read enable) in the FIFO read clock domain.
- Drains each channel in fixed-length bursts, round-robin, and emits tagged 32-bit words on a valid/ready stream toward the host packetiser.
- Tracks FIFO overflow per channel and pads stalled bursts so stream framing is always preserved.

Parameters:
- NUM_CHANNELS, 4, number of ADC channels; legal range 1..16.
- DATA_WIDTH, 12, sample width; legal range 1..12.
- BURST_LEN, 16, words per channel burst; legal range 1..4096.
- TIMEOUT_CYCLES, 1024, empty-stall cycles before a pad word is emitted; 0 disables padding (infinite stall).

Ports:
- clk  in  1  FIFO read clock; wired to the capture block's fifo_rd_clk.
- rst  in  1  synchronous reset, active-high.
- en  in  1  drain enable; sampled only in IDLE.
- fifo_addr  out  $clog2(NUM_CHANNELS)  channel select for the FIFO mux.
- fifo_rd_en  out  NUM_CHANNELS  one-hot read strobe.
- fifo_not_empty  in  1  muxed not-empty flag.
- fifo_full  in  1  muxed full flag.
- fifo_dout  in  DATA_WIDTH  muxed data, valid 1 cycle after rd_en.
- m_data  out  32  {ch[3:0], seq[11:0], pad, 3'b0, sample zero-extended to 12}.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high on the final word of each burst.
- busy  out  1  high in any state except IDLE.
- ovf_flags  out  NUM_CHANNELS  sticky overflow flags, one per channel.
- ovf_clr  in  1  clears all ovf_flags.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high.
- Reset: all outputs are 0. ch=0, fifo_addr=0, burst count=0, stall count=0, all seq counters=0, ovf_flags=0, state=IDLE.
- Reset mid-burst abandons the burst immediately; no m_last is issued.
- State machine:
  - IDLE: if en=1, drive fifo_addr=ch and go to SELECT. Otherwise stay.
  - SELECT: one settle cycle for the mux, then go to WAIT_DATA.
  - WAIT_DATA: if fifo_not_empty=1, pulse fifo_rd_en[ch] for exactly one cycle, clear the stall count, go to LATCH.
  - WAIT_DATA, FIFO empty: increment the stall count. If TIMEOUT_CYCLES≠0 and the stall count reaches TIMEOUT_CYCLES-1, load a pad word (pad=1, sample=0, seq not incremented) and go to SEND.
  - LATCH: register fifo_dout into m_data with pad=0 and the current seq[ch]. Increment seq[ch], wrapping 4095→0. Go to SEND.
  - SEND: m_valid=1. m_data and m_last hold stable until m_ready=1.
  - SEND, on handshake: increment the burst count. If the count equals BURST_LEN, clear it, advance ch (NUM_CHANNELS-1 wraps to 0) and go to IDLE. Otherwise go to WAIT_DATA.
- m_last = (burst count == BURST_LEN-1) while in SEND.
- Latency: en asserted in IDLE with data present gives m_valid 4 cycles later. Steady state is 3 cycles per word with m_ready held high.
- Deasserting en mid-burst has no effect; the burst completes and the block halts in IDLE.
- Only one fifo_rd_en bit is ever high, and never for two consecutive cycles. No reads are issued in IDLE, SELECT, LATCH or SEND.
- Overflow:
  - In any state except IDLE, fifo_full=1 sets ovf_flags[ch].
  - ovf_clr clears all flags.
  - If set and clear occur in the same cycle, set wins.
- Channels are drained in strict order; a channel with an empty FIFO is not skipped. It stalls and then pads.
- The seq counter increments only on real samples, so gaps in seq indicate padding.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, en=0 → all outputs 0; no fifo_rd_en pulse over 100 cycles.
- Basic burst: BURST_LEN=4, ch0 FIFO preloaded with 0x001..0x004, m_ready=1, en=1 → four words {ch=0, seq=0..3, pad=0, sample 0x001..0x004}.
  - First m_valid arrives 4 cycles after en; subsequent words are 3 cycles apart.
  - m_last is high on word 4 only; fifo_addr then becomes 1.
- Backpressure: m_ready=0 for 10 cycles during SEND → m_data and m_last stay stable, no extra fifo_rd_en, and exactly one word transfers when m_ready=1.
- Stall/pad: TIMEOUT_CYCLES=8, ch1 FIFO empty → pad word {ch=1, pad=1, sample=0} emitted after 8 WAIT_DATA cycles. seq[1] is unchanged. A later real sample carries the next seq.
- Round-robin wrap: NUM_CHANNELS=4, all FIFOs full → bursts in channel order 0,1,2,3,0.
  - ovf_flags=4'b1111.
  - ovf_clr pulse → 0. Clear coincident with fifo_full=1 leaves that channel's bit set.
- Reset mid-burst and en drop: assert rst after word 2 → outputs 0 next cycle, seq restarts at 0. Separately, drop en mid-burst → the burst finishes with m_last, then busy=0.
